tmds_multimode_encoder: RTL and testbench

TMDS_MULTIMODE_ENCODER -- requirements
Module: tmds_multimode_encoder

---
 rtl/tmds_pkg.sv | 28 ++
 rtl/tmds_channel_enc.sv | 110 +++++++++++
 rtl/tmds_multimode_encoder.sv | 55 +++++
 tb/tb_tmds_multimode_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants: mode encoding, TERC4 table, control and guard symbols.
// Guard-band symbols are only consumed when TMDS_GUARD_BAND_EN is defined.
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL        = 3'd0,
      MODE_VIDEO       = 3'd1,
      MODE_DATA_ISLAND = 3'd2,
      MODE_VIDEO_GUARD = 3'd3,
      MODE_DATA_GUARD  = 3'd4
   } tmds_mode_e;

   // Packed tables: the first entry listed is the highest index.
   localparam logic [15:0][9:0] TERC4_TABLE = {
      10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
      10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
      10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
      10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
   };

   localparam logic [3:0][9:0] CTRL_SYMS = {
      10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100
   };

   localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
   localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS lane: stage 1 builds q_m and the non-video symbol, stage 2 applies
// DC balance and selects by mode. Guard symbols exist only with TMDS_GUARD_BAND_EN.
module tmds_channel_enc
   import tmds_pkg::*;
`ifdef TMDS_GUARD_BAND_EN
#(
   parameter int CH_IDX   = 0,
   parameter int CH0_SYNC = 1
)
`endif
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_s1,
   input  logic       load_s2,
   input  logic [2:0] mode,
   input  logic [7:0] video,
   input  logic [1:0] ctrl,
   input  logic [3:0] aux,
   output logic [9:0] tmds
);

   logic [3:0]        n1_d;
   logic              use_xnor;
   logic              chain;
   logic [8:0]        qm_d;
   logic [9:0]        sym_d;
   logic              is_video_d;

   logic [8:0]        qm_s1;
   logic [9:0]        sym_s1;
   logic              video_s1;

   logic [3:0]        n1_q;
   logic signed [5:0] bal;
   logic signed [5:0] cnt_ext;
   logic signed [5:0] cnt_nxt;
   logic [9:0]        tmds_d;
   logic signed [4:0] cnt;

   always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, video[i]};
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !video[0]);
      chain    = video[0];
      qm_d     = '0;
      qm_d[0]  = chain;
      for (int i = 1; i < 8; i++) begin
         chain   = use_xnor ? ~(chain ^ video[i]) : (chain ^ video[i]);
         qm_d[i] = chain;
      end
      qm_d[8]    = ~use_xnor;
      is_video_d = (mode == MODE_VIDEO);
      // Anything that is not a recognised non-video mode falls back to control.
      sym_d = CTRL_SYMS[ctrl];
      case (tmds_mode_e'(mode))
         MODE_DATA_ISLAND: sym_d = TERC4_TABLE[aux];
`ifdef TMDS_GUARD_BAND_EN
         MODE_VIDEO_GUARD: sym_d = (CH_IDX % 2 == 0) ? GUARD_EVEN : GUARD_ODD;
         MODE_DATA_GUARD:  sym_d = (CH_IDX == 0 && CH0_SYNC != 0) ?
                                   TERC4_TABLE[{2'b11, ctrl}] : GUARD_ODD;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qm_s1    <= '0;
         sym_s1   <= CTRL_SYMS[0];
         video_s1 <= 1'b0;
      end else if (load_s1) begin
         qm_s1    <= qm_d;
         sym_s1   <= sym_d;
         video_s1 <= is_video_d;
      end
   end

   always_comb begin
      n1_q = '0;
      for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, qm_s1[i]};
      bal     = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      cnt_ext = {cnt[4], cnt};
      tmds_d  = sym_s1;
      cnt_nxt = '0;
      if (video_s1) begin
         if ((cnt == 5'sd0) || (bal == 6'sd0)) begin
            tmds_d  = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_nxt = qm_s1[8] ? (cnt_ext + bal) : (cnt_ext - bal);
         end else if ((!cnt[4] && (bal > 6'sd0)) || (cnt[4] && (bal < 6'sd0))) begin
            tmds_d  = {1'b1, qm_s1[8], ~qm_s1[7:0]};
            cnt_nxt = cnt_ext + (qm_s1[8] ? 6'sd2 : 6'sd0) - bal;
         end else begin
            tmds_d  = {1'b0, qm_s1[8], qm_s1[7:0]};
            cnt_nxt = cnt_ext - (qm_s1[8] ? 6'sd0 : 6'sd2) + bal;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmds <= CTRL_SYMS[0];
         cnt  <= '0;
      end else if (load_s2) begin
         tmds <= tmds_d;
         cnt  <= cnt_nxt[4:0];
      end
   end

endmodule

// File: rtl/tmds_multimode_encoder.sv
// N_CH-lane TMDS encoder with a fixed 2-cycle valid pipeline.
// Define TMDS_GUARD_BAND_EN to enable the video/data guard-band symbols.
module tmds_multimode_encoder #(
   parameter int N_CH     = 3,
   parameter int CH0_SYNC = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   input  logic [2:0]         mode,
   input  logic [8*N_CH-1:0]  video,
   input  logic [2*N_CH-1:0]  ctrl,
   input  logic [4*N_CH-1:0]  aux,
   output logic [10*N_CH-1:0] tmds,
   output logic               out_valid
);

   logic s1_valid;
   logic s2_valid;

   if (N_CH < 1 || N_CH > 4 || CH0_SYNC < 0 || CH0_SYNC > 1) begin : g_bad_cfg
      $error("tmds_multimode_encoder: N_CH must be 1..4 and CH0_SYNC 0 or 1");
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
      end
   end

   assign out_valid = s2_valid;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tmds_channel_enc
`ifdef TMDS_GUARD_BAND_EN
         #(.CH_IDX(i), .CH0_SYNC(CH0_SYNC))
`endif
         u_enc (
            .clk     (clk),
            .reset_n (reset_n),
            .load_s1 (in_valid),
            .load_s2 (s1_valid),
            .mode    (mode),
            .video   (video[8*i +: 8]),
            .ctrl    (ctrl[2*i +: 2]),
            .aux     (aux[4*i +: 4]),
            .tmds    (tmds[10*i +: 10])
         );
   end

endmodule

// File: tb/tb_tmds_multimode_encoder.sv
// Bench for tmds_multimode_encoder: directed vectors plus random traffic checked
// every cycle against a symbol-level model and an expected-symbol queue.
module tb_tmds_multimode_encoder;

   localparam int N_CH = 3;
   localparam int W    = 10 * N_CH;

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic [2:0]        mode;
   logic [8*N_CH-1:0] video;
   logic [2*N_CH-1:0] ctrl;
   logic [4*N_CH-1:0] aux;
   logic [W-1:0]      tmds;
   logic              out_valid;

   tmds_multimode_encoder #(.N_CH(N_CH), .CH0_SYNC(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .mode      (mode),
      .video     (video),
      .ctrl      (ctrl),
      .aux       (aux),
      .tmds      (tmds),
      .out_valid (out_valid)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   localparam logic [9:0] T4 [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };
   localparam logic [9:0] CT [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };
   localparam logic [9:0] RST_SYM = 10'b1101010100;

`ifdef TMDS_GUARD_BAND_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           m_cnt [N_CH];
   logic [W-1:0] exp_q [$];
   int           due_q [$];
   logic [W-1:0] last_exp;

   function automatic logic [9:0] dvi_enc(input logic [7:0] d, input int cnt_in,
                                          output int cnt_out);
      int         n1d, n1, n0;
      logic       xn;
      logic [8:0] qm;
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (cnt_in == 0 || n1 == n0) begin
         dvi_enc = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_out = qm[8] ? cnt_in + n1 - n0 : cnt_in + n0 - n1;
      end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
         dvi_enc = {1'b1, qm[8], ~qm[7:0]};
         cnt_out = cnt_in + (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
         dvi_enc = {1'b0, qm[8], qm[7:0]};
         cnt_out = cnt_in - (qm[8] ? 0 : 2) + n1 - n0;
      end
   endfunction

   function automatic logic [9:0] model_sym(input int ch, input logic [2:0] md,
                                            input logic [7:0] v, input logic [1:0] c,
                                            input logic [3:0] a);
      int nc;
      if (md == 3'd1) begin
         model_sym = dvi_enc(v, m_cnt[ch], nc);
         m_cnt[ch] = nc;
      end else begin
         m_cnt[ch] = 0;
         if (md == 3'd2)                  model_sym = T4[a];
         else if (md == 3'd3 && GUARD_EN) model_sym = (ch % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
         else if (md == 3'd4 && GUARD_EN) model_sym = (ch == 0) ? T4[{2'b11, c}] : 10'b0100110011;
         else                             model_sym = CT[c];
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(posedge clk) begin
      logic [W-1:0] e;
      cyc++;
      if (!reset_n) begin
         exp_q.delete();
         due_q.delete();
         for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
         last_exp = {N_CH{RST_SYM}};
      end else if (in_valid) begin
         for (int ch = 0; ch < N_CH; ch++)
            e[10*ch +: 10] = model_sym(ch, mode, video[8*ch +: 8], ctrl[2*ch +: 2], aux[4*ch +: 4]);
         exp_q.push_back(e);
         due_q.push_back(cyc + 1);
      end
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         check("sb_out_valid", 64'(out_valid), 64'(1'b1));
         check("sb_tmds", 64'(tmds), 64'(exp_q[0]));
         last_exp = exp_q.pop_front();
         void'(due_q.pop_front());
      end else begin
         check("sb_out_valid_idle", 64'(out_valid), 64'(1'b0));
         check("sb_tmds_hold", 64'(tmds), 64'(last_exp));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_raw(input logic [2:0] md, input logic [8*N_CH-1:0] v,
                            input logic [2*N_CH-1:0] c, input logic [4*N_CH-1:0] a);
      in_valid = 1'b1;
      mode     = md;
      video    = v;
      ctrl     = c;
      aux      = a;
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] md, input logic [7:0] v,
                        input logic [1:0] c, input logic [3:0] a);
      drive_raw(md, {N_CH{v}}, {N_CH{c}}, {N_CH{a}});
   endtask

   task automatic idle();
      in_valid = 1'b0;
      mode     = 3'($urandom_range(0, 7));
      video    = (8*N_CH)'($urandom);
      ctrl     = (2*N_CH)'($urandom);
      aux      = (4*N_CH)'($urandom);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_tmds", 64'(tmds), 64'({N_CH{RST_SYM}}));
      check("rst_out_valid", 64'(out_valid), 64'(1'b0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         c;
      logic [9:0] s;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      mode     = '0;
      video    = '0;
      ctrl     = '0;
      aux      = '0;

      s = dvi_enc(8'h00, 0, c);
      check("pin_dvi_first_sym", 64'(s), 64'(10'b0100000000));
      check("pin_dvi_first_cnt", 64'(c), 64'(-8));
      s = dvi_enc(8'h00, -8, c);
      check("pin_dvi_second_sym", 64'(s), 64'(10'b1111111111));
      check("pin_dvi_second_cnt", 64'(c), 64'(2));
      check("pin_terc4_e", 64'(T4[4'hE]), 64'(10'b0101100011));

      @(negedge clk);
      do_reset();

      // Two black pixels: second one inverts to pull disparity back.
      drive(3'd1, 8'h00, 2'b00, 4'h0);
      drive(3'd1, 8'h00, 2'b00, 4'h0);
      check("video00_first", 64'(tmds[9:0]), 64'(10'b0100000000));
      idle();
      check("video00_second", 64'(tmds[9:0]), 64'(10'b1111111111));

      drive(3'd2, 8'h00, 2'b00, 4'h0);
      drive(3'd2, 8'h00, 2'b00, 4'hF);
      check("terc4_0000", 64'(tmds[9:0]), 64'(10'b1010011100));
      idle();
      check("terc4_1111", 64'(tmds[9:0]), 64'(10'b1011000011));

      // A control symbol between pixels must clear the disparity.
      drive(3'd1, 8'h00, 2'b00, 4'h0);
      drive(3'd0, 8'h00, 2'b00, 4'h0);
      drive(3'd1, 8'h00, 2'b00, 4'h0);
      idle();
      check("cnt_cleared", 64'(tmds[9:0]), 64'(10'b0100000000));

      drive(3'd2, 8'h00, 2'b00, 4'h1);
      idle();
      check("gap_ov_a", 64'(out_valid), 64'(1'b1));
      check("gap_sym_a", 64'(tmds[9:0]), 64'(10'b1001100011));
      drive(3'd2, 8'h00, 2'b00, 4'h2);
      check("gap_ov_hole", 64'(out_valid), 64'(1'b0));
      check("gap_hold", 64'(tmds[9:0]), 64'(10'b1001100011));
      idle();
      check("gap_ov_b", 64'(out_valid), 64'(1'b1));
      check("gap_sym_b", 64'(tmds[9:0]), 64'(10'b1011100100));

      drive(3'd4, 8'h00, 2'b10, 4'h0);
      idle();
`ifdef TMDS_GUARD_BAND_EN
      check("dguard_ch0", 64'(tmds[9:0]), 64'(10'b0101100011));
      check("dguard_ch1", 64'(tmds[19:10]), 64'(10'b0100110011));
`else
      check("dguard_ch0", 64'(tmds[9:0]), 64'(10'b0101010100));
      check("dguard_ch1", 64'(tmds[19:10]), 64'(10'b0101010100));
`endif
      drive(3'd3, 8'h00, 2'b01, 4'h0);
      idle();
`ifdef TMDS_GUARD_BAND_EN
      check("vguard_ch0", 64'(tmds[9:0]), 64'(10'b1011001100));
      check("vguard_ch1", 64'(tmds[19:10]), 64'(10'b0100110011));
`else
      check("vguard_ch0", 64'(tmds[9:0]), 64'(10'b0010101011));
      check("vguard_ch1", 64'(tmds[19:10]), 64'(10'b0010101011));
`endif
      drive(3'd6, 8'h00, 2'b11, 4'h0);
      idle();
      check("reserved_as_ctrl", 64'(tmds[9:0]), 64'(10'b1010101011));

      // Reset with symbols in flight; none may emerge afterwards.
      drive(3'd1, 8'h5A, 2'b00, 4'h0);
      drive(3'd1, 8'hC3, 2'b00, 4'h0);
      do_reset();
      drive(3'd1, 8'h00, 2'b00, 4'h0);
      check("post_rst_ov", 64'(out_valid), 64'(1'b0));
      check("post_rst_tmds", 64'(tmds[9:0]), 64'(RST_SYM));
      idle();
      check("post_rst_video", 64'(tmds[9:0]), 64'(10'b0100000000));

      repeat (600) begin
         if ($urandom_range(0, 3) != 0)
            drive_raw(3'($urandom_range(0, 7)), (8*N_CH)'($urandom),
                      (2*N_CH)'($urandom), (4*N_CH)'($urandom));
         else
            idle();
      end
      // Long pixel runs stress the disparity tracking.
      repeat (200) drive_raw(3'd1, (8*N_CH)'($urandom), '0, '0);
      repeat (4) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
